correlator_config_ctrl: RTL and testbench

Clocked command-decode and configuration controller for the correlator. It consumes byte commands from the UART receiver, assembles them into shadow configuration registers, and applies them to the live registers only at an integration boundary. The live registers drive the sample/integration CLK_GEN blocks and the TX_WORD enable. It also generates the per-integration dump and counter-reset strobes for the pulse_counter array.

---
 rtl/correlator_config_ctrl_if.sv | 16 +
 rtl/correlator_config_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_correlator_config_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/correlator_config_ctrl_if.sv
// Received-byte stream from the UART receiver into the correlator
// configuration controller.
interface correlator_config_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output rx_data,
        output rx_valid
    );

    modport slave (
        input rx_data,
        input rx_valid
    );
endinterface

// File: rtl/correlator_config_ctrl.sv
// Byte-command decoder with shadow configuration registers that are
// applied to the live registers at an integration boundary.
module correlator_config_ctrl #(
    parameter logic [63:0] INITIAL_ACTIVE_LINE              = 64'd0,
    parameter logic [63:0] INITIAL_SAMPLE_TIME              = 64'd20,
    parameter logic [63:0] INITIAL_INTEGRATION_TIME         = 64'd20000,
    parameter logic        INITIAL_TRANSMIT_ENABLE          = 1'b0,
    parameter logic        INITIAL_SAMPLE_CLOCK_ENABLE      = 1'b0,
    parameter logic        INITIAL_INTEGRATION_CLOCK_ENABLE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    correlator_config_ctrl_if.slave   rx,
    input  logic                      integration_clk_pulse_i,
    output logic [63:0]               sample_time_o,
    output logic [63:0]               integration_time_o,
    output logic [63:0]               active_line_o,
    output logic                      transmit_enable_o,
    output logic                      sample_clock_enable_o,
    output logic                      integration_clock_enable_o,
    output logic                      dump_o,
    output logic                      reset_correlator_o,
    output logic                      commit_pending_o,
    output logic                      cmd_error_o
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY
    } state_e;

    state_e      state_q;

    logic [63:0] sh_int_q, sh_int_d;
    logic [63:0] sh_smp_q, sh_smp_d;
    logic [63:0] sh_line_q, sh_line_d;
    logic        sh_tx_en_q, sh_tx_en_d;
    logic        sh_int_en_q, sh_int_en_d;
    logic        sh_smp_en_q, sh_smp_en_d;
    logic [4:0]  ridx_q, ridx_d;
    logic        err_q, err_d;
    logic        commit_req;

    logic [63:0] live_int_q, live_smp_q, live_line_q;
    logic        live_tx_en_q, live_int_en_q, live_smp_en_q;
    logic        dump_q, rc_q, pend_q;

    logic [3:0]  op;
    logic [3:0]  pl;
    logic [5:0]  nib;

    assign op  = rx.rx_data[3:0];
    assign pl  = rx.rx_data[7:4];
    assign nib = {ridx_q[3:0], 2'b00};

    always_comb begin
        sh_int_d    = sh_int_q;
        sh_smp_d    = sh_smp_q;
        sh_line_d   = sh_line_q;
        sh_tx_en_d  = sh_tx_en_q;
        sh_int_en_d = sh_int_en_q;
        sh_smp_en_d = sh_smp_en_q;
        ridx_d      = ridx_q;
        err_d       = err_q;
        commit_req  = 1'b0;
        if (rx.rx_valid) begin
            case (op)
                4'd0: begin
                    ridx_d = 5'd0;
                    err_d  = 1'b0;
                    case (pl)
                        4'd1:  sh_int_d  = INITIAL_INTEGRATION_TIME;
                        4'd2:  sh_smp_d  = INITIAL_SAMPLE_TIME;
                        4'd3:  sh_line_d = INITIAL_ACTIVE_LINE;
                        4'd12: begin
                            sh_tx_en_d  = INITIAL_TRANSMIT_ENABLE;
                            sh_int_en_d = INITIAL_INTEGRATION_CLOCK_ENABLE;
                            sh_smp_en_d = INITIAL_SAMPLE_CLOCK_ENABLE;
                        end
                        default: ;
                    endcase
                end
                4'd1, 4'd2, 4'd3: begin
                    // ridx[4] set means all sixteen nibbles are used up
                    if (ridx_q[4]) begin
                        err_d = 1'b1;
                    end else begin
                        if (op == 4'd1) sh_int_d[nib +: 4]  = pl;
                        if (op == 4'd2) sh_smp_d[nib +: 4]  = pl;
                        if (op == 4'd3) sh_line_d[nib +: 4] = pl;
                        ridx_d = ridx_q + 5'd1;
                    end
                end
                4'd12: begin
                    sh_tx_en_d  = rx.rx_data[6];
                    sh_int_en_d = rx.rx_data[5];
                    sh_smp_en_d = rx.rx_data[4];
                end
                4'd13: begin
                    if (state_q == IDLE) begin
                        if (sh_smp_q == 64'd0 || sh_int_q == 64'd0) begin
                            err_d = 1'b1;
                        end else begin
                            ridx_d     = 5'd0;
                            commit_req = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sh_int_q      <= INITIAL_INTEGRATION_TIME;
            sh_smp_q      <= INITIAL_SAMPLE_TIME;
            sh_line_q     <= INITIAL_ACTIVE_LINE;
            sh_tx_en_q    <= INITIAL_TRANSMIT_ENABLE;
            sh_int_en_q   <= INITIAL_INTEGRATION_CLOCK_ENABLE;
            sh_smp_en_q   <= INITIAL_SAMPLE_CLOCK_ENABLE;
            ridx_q        <= 5'd0;
            err_q         <= 1'b0;
            live_int_q    <= INITIAL_INTEGRATION_TIME;
            live_smp_q    <= INITIAL_SAMPLE_TIME;
            live_line_q   <= INITIAL_ACTIVE_LINE;
            live_tx_en_q  <= INITIAL_TRANSMIT_ENABLE;
            live_int_en_q <= INITIAL_INTEGRATION_CLOCK_ENABLE;
            live_smp_en_q <= INITIAL_SAMPLE_CLOCK_ENABLE;
            dump_q        <= 1'b0;
            rc_q          <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            sh_int_q    <= sh_int_d;
            sh_smp_q    <= sh_smp_d;
            sh_line_q   <= sh_line_d;
            sh_tx_en_q  <= sh_tx_en_d;
            sh_int_en_q <= sh_int_en_d;
            sh_smp_en_q <= sh_smp_en_d;
            ridx_q      <= ridx_d;
            err_q       <= err_d;
            dump_q      <= integration_clk_pulse_i;
            // an apply right after a boundary shares the boundary's strobe
            rc_q        <= integration_clk_pulse_i |
                           ((state_q == APPLY) & ~rc_q);
            case (state_q)
                IDLE: begin
                    if (commit_req) begin
                        state_q <= live_int_en_q ? PENDING : APPLY;
                        pend_q  <= live_int_en_q;
                    end
                end
                PENDING: begin
                    if (integration_clk_pulse_i) begin
                        state_q <= APPLY;
                        pend_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    live_int_q    <= sh_int_q;
                    live_smp_q    <= sh_smp_q;
                    live_line_q   <= sh_line_q;
                    live_tx_en_q  <= sh_tx_en_q;
                    live_int_en_q <= sh_int_en_q;
                    live_smp_en_q <= sh_smp_en_q;
                    state_q       <= IDLE;
                    pend_q        <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_time_o              = live_smp_q;
    assign integration_time_o         = live_int_q;
    assign active_line_o              = live_line_q;
    assign transmit_enable_o          = live_tx_en_q;
    assign sample_clock_enable_o      = live_smp_en_q;
    assign integration_clock_enable_o = live_int_en_q;
    assign dump_o                     = dump_q;
    assign reset_correlator_o         = rc_q;
    assign commit_pending_o           = pend_q;
    assign cmd_error_o                = err_q;

endmodule

// File: tb/tb_correlator_config_ctrl.sv
// Directed vector bench for correlator_config_ctrl: a cycle table for the
// apply/strobe timing plus hand-written overflow, reject and reset cases.
module tb_correlator_config_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pulse;
    logic [63:0] smp, itime, line;
    logic        tx_en, smp_en, int_en;
    logic        dump, rc, pend, err;

    int n_total;
    int n_pass;

    correlator_config_ctrl_if rx_if ();

    correlator_config_ctrl dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .rx                         (rx_if),
        .integration_clk_pulse_i    (pulse),
        .sample_time_o              (smp),
        .integration_time_o         (itime),
        .active_line_o              (line),
        .transmit_enable_o          (tx_en),
        .sample_clock_enable_o      (smp_en),
        .integration_clock_enable_o (int_en),
        .dump_o                     (dump),
        .reset_correlator_o         (rc),
        .commit_pending_o           (pend),
        .cmd_error_o                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        pls;
        logic        pend;
        logic        err;
        logic        dump;
        logic        rc;
        logic        ien;
        logic [63:0] smp;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic v, input logic [7:0] d,
                                input logic p, input logic e_pend,
                                input logic e_err, input logic e_dump,
                                input logic e_rc, input logic e_ien,
                                input logic [63:0] e_smp);
        vec_t r;
        r.vld  = v;
        r.data = d;
        r.pls  = p;
        r.pend = e_pend;
        r.err  = e_err;
        r.dump = e_dump;
        r.rc   = e_rc;
        r.ien  = e_ien;
        r.smp  = e_smp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic p);
        rx_if.rx_valid = v;
        rx_if.rx_data  = d;
        pulse          = p;
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        pulse          = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        pulse   = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;

        // cycle-by-cycle: v0-v5 direct apply, v6-v9 enable integration,
        // v10-v15 pending apply, v16-v19 commit coinciding with a boundary
        vecs[0]  = mk(1, 8'h20, 0, 0, 0, 0, 0, 0, 64'd20);
        vecs[1]  = mk(1, 8'h52, 0, 0, 0, 0, 0, 0, 64'd20);
        vecs[2]  = mk(1, 8'h32, 0, 0, 0, 0, 0, 0, 64'd20);
        vecs[3]  = mk(1, 8'h0D, 0, 0, 0, 0, 0, 0, 64'd20);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 64'h35);
        vecs[5]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 64'h35);
        vecs[6]  = mk(1, 8'h2C, 0, 0, 0, 0, 0, 0, 64'h35);
        vecs[7]  = mk(1, 8'h0D, 0, 0, 0, 0, 0, 0, 64'h35);
        vecs[8]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 64'h35);
        vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 64'h35);
        vecs[10] = mk(1, 8'h72, 0, 0, 0, 0, 0, 1, 64'h35);
        vecs[11] = mk(1, 8'h0D, 0, 1, 0, 0, 0, 1, 64'h35);
        vecs[12] = mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 64'h35);
        vecs[13] = mk(0, 8'h00, 1, 0, 0, 1, 1, 1, 64'h35);
        vecs[14] = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 64'h37);
        vecs[15] = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 64'h37);
        vecs[16] = mk(1, 8'h0D, 1, 1, 0, 1, 1, 1, 64'h37);
        vecs[17] = mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 64'h37);
        vecs[18] = mk(0, 8'h00, 1, 0, 0, 1, 1, 1, 64'h37);
        vecs[19] = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 64'h37);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_smp", smp, 64'd20);
        chk("rst_int", itime, 64'd20000);
        chk("rst_line", line, 64'd0);
        chk("rst_en", {tx_en, smp_en, int_en}, 3'b000);
        chk("rst_flags", {dump, rc, pend, err}, 4'b0000);
        rst_n = 1'b1;
        step(0, 8'h00, 0);
        chk("post_rst", {smp, dump, rc, pend, err}, {64'd20, 4'b0000});

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].vld, vecs[i].data, vecs[i].pls);
            chk($sformatf("vec%0d", i),
                {pend, err, dump, rc, int_en, smp},
                {vecs[i].pend, vecs[i].err, vecs[i].dump, vecs[i].rc,
                 vecs[i].ien, vecs[i].smp});
        end
        chk("vec_line_tx", {line, tx_en, smp_en}, {64'd0, 2'b00});

        // nibble overflow on the 17th write, then RESET clears ridx
        step(1, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(1, 8'hF1, 0);
        chk("ovf_16", err, 1'b0);
        step(1, 8'hF1, 0);
        chk("ovf_17", err, 1'b1);
        step(1, 8'h00, 0);
        chk("ovf_clr", err, 1'b0);
        step(1, 8'h31, 0);
        step(1, 8'h20, 0);
        step(1, 8'h0D, 0);
        chk("ovf_pend", pend, 1'b1);
        step(0, 8'h00, 1);
        chk("ovf_pulse", {pend, dump, rc}, 3'b011);
        step(0, 8'h00, 0);
        chk("ovf_int", itime, 64'hFFFF_FFFF_FFFF_FFF3);
        chk("ovf_smp", {smp, rc, dump}, {64'd20, 2'b00});

        // zero sample_time shadow makes COMMIT fail
        step(1, 8'h20, 0);
        for (int i = 0; i < 16; i++) step(1, 8'h02, 0);
        chk("rej_noerr", err, 1'b0);
        step(1, 8'h0D, 0);
        chk("rej_err", {err, pend}, 2'b10);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("rej_live", {smp, rc, pend}, {64'd20, 2'b00});

        // reset while a commit is waiting for its boundary
        step(1, 8'h20, 0);
        chk("rr_errclr", err, 1'b0);
        step(1, 8'h0D, 0);
        chk("rr_pend", pend, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rr_async", {pend, int_en, itime},
            {1'b0, 1'b0, 64'd20000});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 8'h00, 1);
        chk("rr_dump", {dump, rc, pend}, 3'b110);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("rr_live", {itime, smp, line, tx_en, smp_en, int_en, pend},
            {64'd20000, 64'd20, 64'd0, 4'b0000});
        chk("rr_strobes", {dump, rc, err}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
